// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state type, default timing and key polarity for the stopwatch control stage.
package stopwatch_pkg;
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
    localparam int DEF_DEBOUNCE_CYCLES   = 1000000;
    localparam int DEF_TICK_CYCLES       = 500000;
    localparam int DEF_LONG_PRESS_CYCLES = 100000000;
    localparam logic KEY_PRESSED = 1'b0;
endpackage

// File: rtl/stopwatch_key_ctrl_debounce.sv
// key_debounce: 2-flop synchroniser, stable-level debounce counter and one-cycle press pulse.
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic key,
    output logic level,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          settled;
    assign settled = (cnt == CW'(DEBOUNCE_CYCLES - 1));
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync  <= {2{~KEY_PRESSED}};
            cnt   <= '0;
            level <= ~KEY_PRESSED;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], key};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (settled) begin
                cnt   <= '0;
                level <= sync[1];
                press <= (sync[1] == KEY_PRESSED);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/stopwatch_key_ctrl.sv
// stopwatch_key_ctrl: debounced keys, IDLE/RUN/PAUSE control FSM, gated 10 ms tick and status LEDs.
// Optional LONG_PRESS_CLEAR_EN: holding the start key LONG_PRESS_CYCLES raises one clear event.
module stopwatch_key_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_CYCLES       = DEF_TICK_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_display_stop,
    output logic       counter_work,
    output logic       display_work,
    output logic       clear_pulse,
    output logic       tick_10ms,
    output logic [3:0] led
);
    localparam int PW = $clog2(TICK_CYCLES);
    logic          rst_ev, start_ev, disp_ev;
    logic          unused_rst_level, start_level, disp_level;
    logic          long_clear, clear_ev, disp_d, tick_d;
    state_t        state, state_d;
    logic [PW-1:0] presc, presc_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_reset (
        .CLOCK_50(CLOCK_50), .reset(reset), .key(key_reset), .level(unused_rst_level), .press(rst_ev));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_start (
        .CLOCK_50(CLOCK_50), .reset(reset), .key(key_start_pause), .level(start_level), .press(start_ev));
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_display (
        .CLOCK_50(CLOCK_50), .reset(reset), .key(key_display_stop), .level(disp_level), .press(disp_ev));

`ifdef LONG_PRESS_CLEAR_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    logic [HW-1:0] hold;
    // saturates at LONG_PRESS_CYCLES so one hold yields a single clear
    assign long_clear = (start_level == KEY_PRESSED) && (hold == HW'(LONG_PRESS_CYCLES - 1));
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) hold <= '0;
        else hold <= (start_level != KEY_PRESSED) ? '0 :
                     (hold == HW'(LONG_PRESS_CYCLES)) ? hold : hold + HW'(1);
    end
`else
    localparam int unused_long_press = LONG_PRESS_CYCLES;
    assign long_clear = 1'b0;
`endif

    assign clear_ev = rst_ev | long_clear;

    always_comb begin
        state_d = clear_ev ? IDLE : start_ev ? ((state == RUN) ? PAUSE : RUN) : state;
        disp_d  = clear_ev ? 1'b1 : display_work ^ disp_ev;
        tick_d  = !clear_ev && (state == RUN) && (presc == PW'(TICK_CYCLES - 1));
        presc_d = (clear_ev || state == IDLE || tick_d) ? '0 :
                  (state == RUN) ? presc + PW'(1) : presc;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            presc        <= '0;
            counter_work <= 1'b0;
            display_work <= 1'b1;
            clear_pulse  <= 1'b0;
            tick_10ms    <= 1'b0;
        end else begin
            state        <= state_d;
            presc        <= presc_d;
            counter_work <= (state_d == RUN);
            display_work <= disp_d;
            clear_pulse  <= clear_ev;
            tick_10ms    <= tick_d;
        end
    end

    assign led = {disp_level == KEY_PRESSED, start_level == KEY_PRESSED, display_work, counter_work};
endmodule

// File: tb/tb_stopwatch_key_ctrl.sv
// tb_stopwatch_key_ctrl: directed and random key stimulus checked each cycle against a behavioural model.
module tb_stopwatch_key_ctrl;
    localparam int D = 4, T = 5, L = 20;
    logic CLOCK_50 = 1'b0, reset = 1'b0;
    logic key_reset = 1'b1, key_start_pause = 1'b1, key_display_stop = 1'b1;
    logic counter_work, display_work, clear_pulse, tick_10ms;
    logic [3:0] led;
    int checks = 0, errors = 0;

    stopwatch_key_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T), .LONG_PRESS_CYCLES(L)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .key_reset(key_reset), .key_start_pause(key_start_pause),
        .key_display_stop(key_display_stop), .counter_work(counter_work), .display_work(display_work),
        .clear_pulse(clear_pulse), .tick_10ms(tick_10ms), .led(led));

    always #10 CLOCK_50 = ~CLOCK_50;

    // model: 0=idle 1=run 2=pause; run_cycles counts RUN cycles since last clear
    logic [63:0] hist [3];
    bit mdb [3], pend [3];
    bit mdisp, mcw, mclr, mtick;
    int mstate, run_cycles, low_cycles;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin hist[k] = '1; mdb[k] = 1; pend[k] = 0; end
        mstate = 0; run_cycles = 0; low_cycles = 0;
        mdisp = 1; mcw = 0; mclr = 0; mtick = 0;
    endtask

    task automatic model_edge();
        bit clr, flip;
        logic [2:0] raw;
        raw = {key_display_stop, key_start_pause, key_reset};
        low_cycles = mdb[1] ? 0 : low_cycles + 1;
`ifdef LONG_PRESS_CLEAR_EN
        clr = pend[0] || (low_cycles == L);
`else
        clr = pend[0];
`endif
        mtick = 0;
        if (clr) begin
            mstate = 0; run_cycles = 0; mdisp = 1;
        end else begin
            if (mstate == 1) begin run_cycles++; mtick = (run_cycles % T == 0); end
            if (pend[1]) mstate = (mstate == 1) ? 2 : 1;
            if (pend[2]) mdisp = !mdisp;
        end
        mclr = clr;
        mcw = (mstate == 1);
        // a level is accepted once D consecutive synchronised samples disagree with it
        for (int k = 0; k < 3; k++) begin
            hist[k] = {hist[k][62:0], raw[k]};
            flip = 1;
            for (int j = 2; j < D + 2; j++) if (hist[k][j] == mdb[k]) flip = 0;
            pend[k] = flip && mdb[k];
            if (flip) mdb[k] = !mdb[k];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("counter_work", {31'b0, counter_work}, {31'b0, mcw});
        chk("display_work", {31'b0, display_work}, {31'b0, mdisp});
        chk("clear_pulse", {31'b0, clear_pulse}, {31'b0, mclr});
        chk("tick_10ms", {31'b0, tick_10ms}, {31'b0, mtick});
        chk("led", {28'b0, led}, {28'b0, !mdb[2], !mdb[1], mdisp, mcw});
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_edge();
        @(negedge CLOCK_50);
        check_all();
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic set_key(input int k, input logic v);
        if (k == 0) key_reset = v;
        else if (k == 1) key_start_pause = v;
        else key_display_stop = v;
    endtask

    task automatic press(input int k, input int hold);
        set_key(k, 1'b0);
        cyc(hold);
        set_key(k, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge CLOCK_50);
        reset = 1'b1;
        model_reset();
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check_all();
        chk("reset_led", {28'b0, led}, 32'h2);
        reset = 1'b0;
    endtask

    initial begin
        int n;
        do_reset();
        cyc(50);
        press(1, 10); cyc(20);
        chk("start_enters_run", {31'b0, counter_work}, 32'd1);
        press(1, 3); cyc(15);
        chk("glitch_keeps_run", {31'b0, counter_work}, 32'd1);
        press(0, 6); cyc(10);
        press(1, 6); cyc(6);
        press(1, 6); cyc(10);
        chk("paused", {31'b0, counter_work}, 32'd0);
        key_start_pause = 1'b0;
        n = 0;
        while (!counter_work && n < 20) begin step(); n++; end
        chk("resume_seen", {31'b0, counter_work}, 32'd1);
        key_start_pause = 1'b1;
        n = 0;
        do begin step(); n++; end while (!tick_10ms && n < 10);
        chk("resume_tick_latency", n, 32'd3);
        cyc(5);
        key_reset = 1'b0; key_start_pause = 1'b0;
        cyc(8);
        key_reset = 1'b1; key_start_pause = 1'b1;
        cyc(10);
        chk("clear_wins_idle", {31'b0, counter_work}, 32'd0);
        press(2, 6); cyc(8);
        chk("display_frozen", {31'b0, display_work}, 32'd0);
        press(2, 6); cyc(8);
        chk("display_follow", {31'b0, display_work}, 32'd1);
        press(2, 6); cyc(8);
        press(0, 6); cyc(8);
        chk("clear_unfreezes", {31'b0, display_work}, 32'd1);
        press(1, 30); cyc(10);
        press(1, 6); cyc(3);
        key_start_pause = 1'b0;
        do_reset();
        cyc(12);
        key_start_pause = 1'b1;
        cyc(10);
        repeat (400) begin
            if ($urandom_range(15) == 0) key_reset = ~key_reset;
            if ($urandom_range(5) == 0) key_start_pause = ~key_start_pause;
            if ($urandom_range(5) == 0) key_display_stop = ~key_display_stop;
            step();
        end
        key_reset = 1'b1; key_start_pause = 1'b1; key_display_stop = 1'b1;
        cyc(20);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
